// File: rtl/peak_rv32im_reg_arb.sv
// Debug-port arbiter: halts the core, performs one regfile read/write through the AR port, then acks.
// Optional halt timeout is compiled in with PEAK_REG_ARB_TIMEOUT_EN.
module peak_rv32im_reg_arb #(
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DBG_REQ,
    input  logic        DBG_WR,
    input  logic [4:0]  DBG_ADDR,
    input  logic [31:0] DBG_WDATA,
    input  logic        DBG_HOLD,
    output logic        DBG_ACK,
    output logic        DBG_ERR,
    output logic [31:0] DBG_RDATA,
    output logic        CORE_HALT_REQ,
    input  logic        CORE_HALTED,
    output logic        RF_EN,
    output logic        RF_WR,
    output logic [15:0] RF_AD,
    output logic [31:0] RF_DI,
    input  logic [31:0] RF_DO,
    output logic [2:0]  FSM_STATE
);

    // Handshake: DBG_REQ is a level held until DBG_ACK; DBG_ACK is a one-cycle pulse with
    // DBG_ERR/DBG_RDATA valid alongside it; DBG_REQ in RESP or the cycle after is ignored.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        ACCESS    = 3'd2,
        CAPTURE   = 3'd3,
        RESP      = 3'd4,
        HELD      = 3'd5
    } state_t;

    state_t      state, state_n;
    logic        lat_wr, lat_wr_n;
    logic [4:0]  lat_addr, lat_addr_n;
    logic [31:0] lat_wdata, lat_wdata_n;
    logic        post_ack;
    logic        req_ok;
    logic        timeout_hit;

    assign req_ok    = DBG_REQ && !post_ack;
    assign FSM_STATE = state;

`ifdef PEAK_REG_ARB_TIMEOUT_EN
    logic [7:0] halt_cnt;
    logic       err_q;

    // Counter sits at zero outside HALT_WAIT, so it is already clear on entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            halt_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            halt_cnt <= (state == HALT_WAIT) ? halt_cnt + 8'd1 : 8'd0;
            err_q    <= timeout_hit;
        end
    end

    assign timeout_hit = (state == HALT_WAIT) && !CORE_HALTED && (halt_cnt == 8'(HALT_TIMEOUT));
    assign DBG_ERR     = err_q;
`else
    assign timeout_hit = 1'b0;
    assign DBG_ERR     = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        lat_wr_n    = lat_wr;
        lat_addr_n  = lat_addr;
        lat_wdata_n = lat_wdata;
        case (state)
            IDLE: begin
                if (req_ok) begin
                    lat_wr_n    = DBG_WR;
                    lat_addr_n  = DBG_ADDR;
                    lat_wdata_n = DBG_WDATA;
                    state_n     = HALT_WAIT;
                end
            end
            HALT_WAIT: begin
                if (CORE_HALTED)
                    state_n = (lat_wr && lat_addr == 5'd0) ? RESP : ACCESS;
                else if (timeout_hit)
                    state_n = RESP;
            end
            ACCESS:  state_n = lat_wr ? RESP : CAPTURE;
            CAPTURE: state_n = RESP;
            // A timed-out request never parks the core in HELD.
            RESP:    state_n = (DBG_HOLD && !DBG_ERR) ? HELD : IDLE;
            HELD: begin
                if (req_ok) begin
                    lat_wr_n    = DBG_WR;
                    lat_addr_n  = DBG_ADDR;
                    lat_wdata_n = DBG_WDATA;
                    state_n     = (DBG_WR && DBG_ADDR == 5'd0) ? RESP : ACCESS;
                end else if (!DBG_HOLD) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            lat_wr        <= 1'b0;
            lat_addr      <= 5'd0;
            lat_wdata     <= 32'd0;
            post_ack      <= 1'b0;
            DBG_ACK       <= 1'b0;
            DBG_RDATA     <= 32'd0;
            CORE_HALT_REQ <= 1'b0;
            RF_EN         <= 1'b0;
            RF_WR         <= 1'b0;
            RF_AD         <= 16'd0;
            RF_DI         <= 32'd0;
        end else begin
            state         <= state_n;
            lat_wr        <= lat_wr_n;
            lat_addr      <= lat_addr_n;
            lat_wdata     <= lat_wdata_n;
            post_ack      <= (state == RESP);
            DBG_ACK       <= (state_n == RESP);
            CORE_HALT_REQ <= (state_n != IDLE);
            RF_EN         <= (state_n == ACCESS);
            RF_WR         <= (state_n == ACCESS) && lat_wr_n;
            RF_AD         <= (state_n == ACCESS) ? {8'h10, 3'b000, lat_addr_n} : 16'd0;
            RF_DI         <= (state_n == ACCESS) ? lat_wdata_n : 32'd0;
            if (state == CAPTURE)
                DBG_RDATA <= RF_DO;
            else if (timeout_hit)
                DBG_RDATA <= 32'd0;
        end
    end

endmodule

// File: tb/tb_peak_rv32im_reg_arb.sv
// Bench for peak_rv32im_reg_arb: directed steps plus a random request loop against a
// regfile/latency reference model.
module tb_peak_rv32im_reg_arb;

    localparam int         TB_TIMEOUT = 4;
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CAPTURE  = 3'd3;
    localparam logic [2:0] S_HELD     = 3'd5;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        DBG_REQ = 1'b0;
    logic        DBG_WR = 1'b0;
    logic [4:0]  DBG_ADDR = 5'd0;
    logic [31:0] DBG_WDATA = 32'd0;
    logic        DBG_HOLD = 1'b0;
    logic        CORE_HALTED = 1'b1;
    logic [31:0] RF_DO = 32'd0;
    logic        DBG_ACK, DBG_ERR, CORE_HALT_REQ, RF_EN, RF_WR;
    logic [31:0] DBG_RDATA, RF_DI;
    logic [15:0] RF_AD;
    logic [2:0]  FSM_STATE;

    always #5 CLK = ~CLK;

    peak_rv32im_reg_arb #(.HALT_TIMEOUT(TB_TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .DBG_REQ(DBG_REQ), .DBG_WR(DBG_WR), .DBG_ADDR(DBG_ADDR),
        .DBG_WDATA(DBG_WDATA), .DBG_HOLD(DBG_HOLD), .DBG_ACK(DBG_ACK), .DBG_ERR(DBG_ERR),
        .DBG_RDATA(DBG_RDATA), .CORE_HALT_REQ(CORE_HALT_REQ), .CORE_HALTED(CORE_HALTED),
        .RF_EN(RF_EN), .RF_WR(RF_WR), .RF_AD(RF_AD), .RF_DI(RF_DI), .RF_DO(RF_DO),
        .FSM_STATE(FSM_STATE)
    );

    // Reference model state
    logic [31:0] model[32];
    logic [31:0] exp_q[$];
    logic [31:0] last_rdata = 32'd0;
    logic        in_held = 1'b0;
    int          checks = 0;
    int          passes = 0;
    logic        halt_track = 1'b0;

    // Regfile environment: reloads from the model during reset, read data one cycle after address.
    logic [31:0] mem[32];
    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) mem[i] <= model[i];
        end else if (RF_EN) begin
            if (RF_WR) mem[RF_AD[4:0]] <= RF_DI;
            RF_DO <= mem[RF_AD[4:0]];
        end
    end

    // Port monitor
    int          rf_en_total = 0;
    int          rf_idle_bad = 0;
    int          halt_drop = 0;
    logic [15:0] last_ad = 16'd0;
    logic        last_wr = 1'b0;
    logic [31:0] last_di = 32'd0;
    always @(posedge CLK) begin
        if (RF_EN) begin
            rf_en_total++;
            last_ad = RF_AD;
            last_wr = RF_WR;
            last_di = RF_DI;
        end else if (RF_WR || RF_AD != 16'd0 || RF_DI != 32'd0) begin
            rf_idle_bad++;
        end
        if (halt_track && !CORE_HALT_REQ) halt_drop++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // d: extra HALT_WAIT cycles before CORE_HALTED rises (negative = never).
    task automatic do_access(input string tag, input logic wr, input logic [4:0] addr,
                             input logic [31:0] wdata, input logic hold, input int d,
                             input logic drop_late, input logic expect_to);
        int          exp_lat, lat, en0;
        logic        skip;
        logic [31:0] exp_rd;
        skip = wr && addr == 5'd0;
        if (expect_to) exp_lat = TB_TIMEOUT + 2;
        else begin
            exp_lat = wr ? (skip ? 1 : 2) : 3;
            if (!in_held) exp_lat += 1 + d;
        end
        exp_rd = expect_to ? 32'd0 : (wr ? last_rdata : model[addr]);
        exp_q.push_back(exp_rd);

        @(negedge CLK);
        DBG_REQ = 1'b1; DBG_WR = wr; DBG_ADDR = addr; DBG_WDATA = wdata; DBG_HOLD = hold;
        CORE_HALTED = !expect_to && (in_held || d == 0);
        en0 = rf_en_total;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge CLK); #1;
            if (n == 1) begin
                DBG_WR = 1'($urandom); DBG_ADDR = 5'($urandom); DBG_WDATA = $urandom;
            end
            if (!expect_to && d > 0 && n == 1 + d) CORE_HALTED = 1'b1;
            if (drop_late && n == 2 + d) CORE_HALTED = 1'b0;
            if (DBG_ACK) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_err"}, 64'(DBG_ERR), 64'(expect_to));
        check({tag, "_rdata"}, 64'(DBG_RDATA), 64'(exp_q.pop_front()));
        check({tag, "_halt_req_at_ack"}, 64'(CORE_HALT_REQ), 64'd1);
        check({tag, "_rf_en_count"}, 64'(rf_en_total - en0), (skip || expect_to) ? 64'd0 : 64'd1);
        if (!skip && !expect_to) begin
            check({tag, "_rf_ad"}, 64'(last_ad), 64'({11'h080, addr}));
            check({tag, "_rf_wr"}, 64'(last_wr), 64'(wr));
            check({tag, "_rf_di"}, 64'(last_di), 64'(wdata));
        end
        if (wr && !skip && !expect_to) model[addr] = wdata;
        last_rdata = exp_rd;
        in_held = hold && !expect_to;
        @(posedge CLK); #1;
        check({tag, "_ack_one_cycle"}, 64'(DBG_ACK), 64'd0);
        @(posedge CLK); #1;
        DBG_REQ = 1'b0;
        CORE_HALTED = 1'b1;
        check({tag, "_state_after"}, 64'(FSM_STATE), in_held ? 64'(S_HELD) : 64'(S_IDLE));
        check({tag, "_halt_req_after"}, 64'(CORE_HALT_REQ), 64'(in_held));
    endtask

    task automatic release_hold();
        @(negedge CLK);
        DBG_HOLD = 1'b0;
        @(posedge CLK); #1;
        check("release_halt_req", 64'(CORE_HALT_REQ), 64'd0);
        check("release_state", 64'(FSM_STATE), 64'(S_IDLE));
        in_held = 1'b0;
    endtask

    initial begin
        int   drops0, bad;
        logic ack_seen;
        logic wr, hold;
        logic [4:0] addr;

        model[0] = 32'd0;
        for (int i = 1; i < 32; i++) model[i] = $urandom;
        model[5] = 32'hDEADBEEF;

        // Reset
        repeat (3) @(posedge CLK);
        #1;
        check("reset_ctrl", 64'({DBG_ACK, DBG_ERR, CORE_HALT_REQ, RF_EN, RF_WR, RF_AD, FSM_STATE}), 64'd0);
        check("reset_data", {DBG_RDATA, RF_DI}, 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        do_access("read_x5", 1'b0, 5'd5, 32'd0, 1'b0, 0, 1'b0, 1'b0);
        do_access("write_x31", 1'b1, 5'd31, 32'h12345678, 1'b0, 0, 1'b0, 1'b0);
        do_access("read_x31", 1'b0, 5'd31, $urandom, 1'b0, 0, 1'b0, 1'b0);
        do_access("write_x0", 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 0, 1'b0, 1'b0);
        do_access("read_x0", 1'b0, 5'd0, 32'd0, 1'b0, 0, 1'b0, 1'b0);

        do_access("hold_read_x1", 1'b0, 5'd1, 32'd0, 1'b1, 0, 1'b0, 1'b0);
        drops0 = halt_drop;
        halt_track = 1'b1;
        do_access("hold_read_x2", 1'b0, 5'd2, 32'd0, 1'b1, 0, 1'b0, 1'b0);
        halt_track = 1'b0;
        check("hold_no_halt_drop", 64'(halt_drop - drops0), 64'd0);
        do_access("held_write_x0", 1'b1, 5'd0, $urandom, 1'b1, 0, 1'b0, 1'b0);
        release_hold();

        do_access("slow_halt_read", 1'b0, 5'd9, 32'd0, 1'b0, 2, 1'b0, 1'b0);
        do_access("halt_drop_in_access", 1'b0, 5'd10, 32'd0, 1'b0, 0, 1'b1, 1'b0);

`ifdef PEAK_REG_ARB_TIMEOUT_EN
        do_access("halt_timeout", 1'b0, 5'd12, $urandom, 1'b1, -1, 1'b0, 1'b1);
`endif

        // Reset while the read sits in CAPTURE
        @(negedge CLK);
        DBG_REQ = 1'b1; DBG_WR = 1'b0; DBG_ADDR = 5'd7; DBG_HOLD = 1'b0; CORE_HALTED = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("mid_state_capture", 64'(FSM_STATE), 64'(S_CAPTURE));
        RST = 1'b1;
        @(posedge CLK); #1;
        check("rst_capture_ctrl", 64'({DBG_ACK, DBG_ERR, CORE_HALT_REQ, RF_EN, RF_WR, RF_AD, FSM_STATE}), 64'd0);
        check("rst_capture_data", {DBG_RDATA, RF_DI}, 64'd0);
        RST = 1'b0;
        DBG_REQ = 1'b0;
        last_rdata = 32'd0;
        in_held = 1'b0;
        ack_seen = 1'b0;
        repeat (6) begin
            @(posedge CLK); #1;
            if (DBG_ACK) ack_seen = 1'b1;
        end
        check("rst_no_stale_ack", 64'(ack_seen), 64'd0);
        do_access("read_after_rst", 1'b0, 5'd7, 32'd0, 1'b0, 0, 1'b0, 1'b0);

        // Random requests
        for (int k = 0; k < 14; k++) begin
            if (in_held && $urandom_range(0, 2) == 0) release_hold();
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            hold = 1'($urandom_range(0, 1));
            do_access("rand", wr, addr, $urandom, hold, in_held ? 0 : $urandom_range(0, 3), 1'b0, 1'b0);
        end
        if (in_held) release_hold();

        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== model[i]) bad++;
        check("regfile_contents", 64'(bad), 64'd0);
        check("rf_zero_outside_access", 64'(rf_idle_bad), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
